// File: rtl/pengo_pkg.sv
// Shared types and constants for the pengo core glue logic.
package pengo_pkg;

   typedef enum logic [2:0] {
      ARB_IDLE,
      ARB_WAIT_VB,
      ARB_SETTLE,
      ARB_GRANT,
      ARB_RELEASE
   } arb_state_t;

   // 10 seconds of clk at 24 MHz
   localparam int unsigned DIM_10S_24M = 240000000;

   // Width of a counter that must hold the values 0 .. n-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hs_ram_arbiter_if.sv
// Signals between hps_io/hiscore, the core top level and the work-RAM arbiter.
interface hs_ram_arbiter_if;
   import pengo_pkg::*;

   logic       pause_btn;
   logic       vblank;
   // hs_req is a level held by the hiscore engine for as long as it needs the RAM;
   // hs_grant rises only once the core is halted past a vblank, stays high while
   // hs_req stays high, and falls the cycle after hs_req drops.
   logic       hs_req;
   logic       hs_grant;
   logic       ram_sel;
   logic       pause_out;
   logic       user_paused;
   logic       dim_out;
   arb_state_t state;

   modport slave (
      input  pause_btn, vblank, hs_req,
      output hs_grant, ram_sel, pause_out, user_paused, dim_out, state
   );

   modport master (
      output pause_btn, vblank, hs_req,
      input  hs_grant, ram_sel, pause_out, user_paused, dim_out, state
   );

endinterface

// File: rtl/pause_dim_timer.sv
// User pause toggle and the screen-dim timer that runs while the user pause is held.
module pause_dim_timer
   import pengo_pkg::*;
#(
   parameter int unsigned DIM_CYCLES = DIM_10S_24M,
   parameter int unsigned TIMER_W    = 28
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pause_btn,
   output logic user_paused,
   output logic user_paused_nxt,
   output logic dim_out
);

   localparam logic [TIMER_W-1:0] DIM_LIMIT = TIMER_W'(DIM_CYCLES);

   logic               btn_d1;
   logic [TIMER_W-1:0] timer;

   // The arbiter registers pause_out from the next toggle value so both flip together.
   assign user_paused_nxt = user_paused ^ (pause_btn & ~btn_d1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_d1      <= 1'b0;
         user_paused <= 1'b0;
         timer       <= '0;
         dim_out     <= 1'b0;
      end else begin
         btn_d1      <= pause_btn;
         user_paused <= user_paused_nxt;
         if (!user_paused) begin
            timer <= '0;
         end else if (timer < DIM_LIMIT) begin
            timer <= timer + 1'b1;
         end
         // Gating with user_paused drops dim one cycle after unpause instead of two.
         dim_out     <= user_paused && (timer >= DIM_LIMIT);
      end
   end

endmodule

// File: rtl/hs_ram_arbiter.sv
// Work-RAM port arbiter between the CPU and the hiscore engine, plus the combined core pause.
// The port is handed over only after the core is halted and a fresh vblank edge has settled.
module hs_ram_arbiter
   import pengo_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned DIM_CYCLES    = DIM_10S_24M,
   parameter int unsigned TIMER_W       = 28
) (
   input  logic            clk,
   input  logic            reset_n,
   hs_ram_arbiter_if.slave bus
);

   localparam int unsigned      CNT_W       = cnt_width(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             vblank_d1;
   logic             vb_rise;
   logic             grant_q;
   logic             pause_q;
   logic             user_paused;
   logic             user_paused_nxt;
   logic             dim;

   pause_dim_timer #(
      .DIM_CYCLES (DIM_CYCLES),
      .TIMER_W    (TIMER_W)
   ) u_pause_dim (
      .clk             (clk),
      .reset_n         (reset_n),
      .pause_btn       (bus.pause_btn),
      .user_paused     (user_paused),
      .user_paused_nxt (user_paused_nxt),
      .dim_out         (dim)
   );

   // vblank_d1 tracks every cycle, so a vblank already high on entry never looks like an edge.
   assign vb_rise = bus.vblank & ~vblank_d1;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ARB_IDLE: begin
            if (bus.hs_req) state_nxt = ARB_WAIT_VB;
         end
         ARB_WAIT_VB: begin
            if (!bus.hs_req) begin
               state_nxt = ARB_IDLE;
            end else if (vb_rise) begin
               state_nxt = ARB_SETTLE;
               cnt_nxt   = '0;
            end
         end
         ARB_SETTLE: begin
            if (!bus.hs_req) begin
               state_nxt = ARB_IDLE;
            end else if (cnt == SETTLE_LAST) begin
               state_nxt = ARB_GRANT;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ARB_GRANT: begin
            if (!bus.hs_req) state_nxt = ARB_RELEASE;
         end
         ARB_RELEASE: begin
            state_nxt = ARB_IDLE;
         end
         default: begin
            state_nxt = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ARB_IDLE;
         cnt       <= '0;
         vblank_d1 <= 1'b0;
         grant_q   <= 1'b0;
         pause_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         vblank_d1 <= bus.vblank;
         grant_q   <= (state_nxt == ARB_GRANT);
         pause_q   <= user_paused_nxt | (state_nxt != ARB_IDLE);
      end
   end

   // One flop drives both so grant and mux select can never disagree.
   assign bus.hs_grant    = grant_q;
   assign bus.ram_sel     = grant_q;
   assign bus.pause_out   = pause_q;
   assign bus.user_paused = user_paused;
   assign bus.dim_out     = dim;
   assign bus.state       = state;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Bench for hs_ram_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_hs_ram_arbiter;
   import pengo_pkg::*;

   localparam int SETTLE = 4;
   localparam int DIM    = 100;
   localparam int W      = 6;

   // ---------------- clock / reset ----------------
   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   hs_ram_arbiter_if bus_if();

   hs_ram_arbiter #(
      .SETTLE_CYCLES (SETTLE),
      .DIM_CYCLES    (DIM),
      .TIMER_W       (8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish, got timeout, required finish before 2000000 ns");
      $fatal(1, "watchdog expired");
   end

   // ---------------- counters / scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] cmp_exp;
   logic [W-1:0] cmp_act;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Expected outputs after each clock edge: {idle, hs_grant, ram_sel, pause_out, user_paused, dim_out}.
   // Dim: high once user_paused has been seen high on DIM+1 consecutive cycles before this edge.
   // Arbiter: a request session starts on hs_req, waits for a vblank rise seen while waiting,
   // grants SETTLE edges after that rise, and ends one cycle after hs_req drops.
   bit m_up, m_btn_prev, m_vb_prev, m_dim;
   int m_run;
   bit m_busy, m_granted, m_releasing;
   int m_vb_edge, m_edge;

   task automatic model_reset();
      m_up = 0; m_btn_prev = 0; m_vb_prev = 0; m_dim = 0; m_run = 0;
      m_busy = 0; m_granted = 0; m_releasing = 0; m_vb_edge = -1; m_edge = 0;
   endtask

   task automatic model_edge(input logic req, input logic vb, input logic btn);
      m_dim = (m_run >= DIM + 1);
      if (btn && !m_btn_prev) m_up = !m_up;
      m_btn_prev = btn;
      m_run = m_up ? ((m_run > DIM) ? DIM + 1 : m_run + 1) : 0;
      if (!m_busy) begin
         if (req) begin
            m_busy    = 1;
            m_vb_edge = -1;
         end
      end else if (m_releasing) begin
         m_releasing = 0;
         m_busy      = 0;
      end else if (m_granted) begin
         if (!req) begin
            m_granted   = 0;
            m_releasing = 1;
         end
      end else if (!req) begin
         m_busy = 0;
      end else if (m_vb_edge < 0) begin
         if (vb && !m_vb_prev) m_vb_edge = m_edge;
      end else if (m_edge - m_vb_edge == SETTLE) begin
         m_granted = 1;
      end
      m_vb_prev = vb;
      m_edge++;
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         model_reset();
         exp_q.delete();
         exp_q.push_back(6'b100000);
      end else begin
         model_edge(bus_if.hs_req, bus_if.vblank, bus_if.pause_btn);
         exp_q.push_back({!m_busy, m_granted, m_granted, m_up | m_busy, m_up, m_dim});
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cmp_exp = exp_q.pop_front();
         cmp_act = {bus_if.state == ARB_IDLE, bus_if.hs_grant, bus_if.ram_sel,
                    bus_if.pause_out, bus_if.user_paused, bus_if.dim_out};
         n_checks++;
         if (cmp_act !== cmp_exp) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t: got %b, required %b (idle,grant,sel,pause,user,dim)",
                     $time, cmp_act, cmp_exp);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press_btn();
      bus_if.pause_btn = 1'b1;
      step();
      bus_if.pause_btn = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus_if.pause_btn = 1'b0;
      bus_if.vblank    = 1'b0;
      bus_if.hs_req    = 1'b0;
      reset_n          = 1'b0;
      step(3);
      reset_n = 1'b1;
      check("reset_hs_grant", bus_if.hs_grant, 0);
      check("reset_ram_sel", bus_if.ram_sel, 0);
      check("reset_pause_out", bus_if.pause_out, 0);
      check("reset_user_paused", bus_if.user_paused, 0);
      check("reset_dim_out", bus_if.dim_out, 0);
      check("reset_state", bus_if.state, ARB_IDLE);

      // pause toggle and dim timer
      step(2);
      press_btn();
      check("t1_user_paused", bus_if.user_paused, 1);
      check("t1_pause_out", bus_if.pause_out, 1);
      step(100);
      check("t1_dim_before", bus_if.dim_out, 0);
      step();
      check("t1_dim_at_101", bus_if.dim_out, 1);
      check("t1_model_dim", m_dim, 1);
      press_btn();
      check("t1_unpaused", bus_if.user_paused, 0);
      check("t1_pause_off", bus_if.pause_out, 0);
      step();
      check("t1_dim_cleared", bus_if.dim_out, 0);

      // held button toggles once; unpause while the arbiter holds pause
      bus_if.pause_btn = 1'b1;
      step(5);
      check("held_toggle_once", bus_if.user_paused, 1);
      bus_if.pause_btn = 1'b0;
      step();
      check("held_release", bus_if.user_paused, 1);
      bus_if.hs_req = 1'b1;
      step();
      press_btn();
      check("unpause_in_wait_user", bus_if.user_paused, 0);
      check("unpause_in_wait_pause", bus_if.pause_out, 1);
      bus_if.hs_req = 1'b0;
      step();
      check("abort_wait_pause", bus_if.pause_out, 0);

      // grant latency after a vblank rise
      step(2);
      bus_if.hs_req = 1'b1;
      step();
      check("t2_pause_plus1", bus_if.pause_out, 1);
      check("t2_no_grant", bus_if.hs_grant, 0);
      step(49);
      check("t2_no_grant_49", bus_if.hs_grant, 0);
      bus_if.vblank = 1'b1;
      step(4);
      check("t2_grant_at_4", bus_if.hs_grant, 0);
      step();
      check("t2_grant_at_5", bus_if.hs_grant, 1);
      check("t2_ram_sel_at_5", bus_if.ram_sel, 1);
      check("t2_state_grant", bus_if.state, ARB_GRANT);
      check("t2_model_grant", m_granted, 1);

      // release sequence
      bus_if.vblank = 1'b0;
      step(3);
      bus_if.hs_req = 1'b0;
      step();
      check("t3_ram_sel_drop", bus_if.ram_sel, 0);
      check("t3_pause_held", bus_if.pause_out, 1);
      step();
      check("t3_pause_drop", bus_if.pause_out, 0);
      check("t3_state_idle", bus_if.state, ARB_IDLE);

      // abort in SETTLE
      step(2);
      bus_if.hs_req = 1'b1;
      step(3);
      bus_if.vblank = 1'b1;
      step(3);
      bus_if.hs_req = 1'b0;
      step();
      check("t4_state_idle", bus_if.state, ARB_IDLE);
      check("t4_pause_out", bus_if.pause_out, 0);
      step(10);
      check("t4_no_grant", bus_if.hs_grant, 0);
      bus_if.vblank = 1'b0;
      step(2);

      // vblank already high on entry
      bus_if.vblank = 1'b1;
      step(3);
      bus_if.hs_req = 1'b1;
      step(20);
      check("t5_no_grant_high_vb", bus_if.hs_grant, 0);
      check("t5_state_wait", bus_if.state, ARB_WAIT_VB);
      bus_if.vblank = 1'b0;
      step(3);
      bus_if.vblank = 1'b1;
      step(4);
      check("t5_grant_at_4", bus_if.hs_grant, 0);
      step();
      check("t5_grant_at_5", bus_if.hs_grant, 1);

      // re-request during RELEASE is ignored until IDLE
      bus_if.hs_req = 1'b0;
      step();
      check("rel_state", bus_if.state, ARB_RELEASE);
      bus_if.hs_req = 1'b1;
      step();
      check("rel_then_idle", bus_if.state, ARB_IDLE);
      check("rel_idle_pause", bus_if.pause_out, 0);
      step();
      check("rel_new_wait", bus_if.state, ARB_WAIT_VB);

      // reset mid-GRANT with the user paused
      bus_if.vblank = 1'b0;
      step(2);
      press_btn();
      bus_if.vblank = 1'b1;
      step(5);
      check("t6_grant", bus_if.hs_grant, 1);
      check("t6_user_paused", bus_if.user_paused, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_rst_grant", bus_if.hs_grant, 0);
      check("t6_rst_ram_sel", bus_if.ram_sel, 0);
      check("t6_rst_pause", bus_if.pause_out, 0);
      check("t6_rst_user", bus_if.user_paused, 0);
      check("t6_rst_dim", bus_if.dim_out, 0);
      @(posedge clk);
      #1;
      bus_if.vblank = 1'b0;
      reset_n = 1'b1;
      check("t6_after_rst_idle", bus_if.state, ARB_IDLE);
      step();
      check("t6_restart_wait", bus_if.state, ARB_WAIT_VB);
      check("t6_restart_pause", bus_if.pause_out, 1);
      bus_if.hs_req = 1'b0;
      step(2);

      // random traffic checked every cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) bus_if.hs_req = ~bus_if.hs_req;
         if ($urandom_range(0, 14) == 0) bus_if.vblank = ~bus_if.vblank;
         bus_if.pause_btn = ($urandom_range(0, 149) == 0);
         if (i == 1500) begin
            #3;
            reset_n = 1'b0;
            #4;
            reset_n = 1'b1;
         end
         step();
      end
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
